// File: rtl/sprite_anim_renderer_pkg.sv
// Shared display package: screen geometry, colour depth and asset location
// used by the sprite renderer, plus the overflow-safe span test it relies on.
package sprite_anim_renderer_pkg;

    localparam int    VIDEO_WIDTH    = 640;
    localparam int    VIDEO_HEIGHT   = 480;
    localparam int    BITS_PER_COLOR = 12;
    localparam string FILES_PATH     = "../assetsMemFiles/";

    // Coordinate widths derived from the visible raster (10 bits for x, 9 for y).
    localparam int X_W = $clog2(VIDEO_WIDTH);
    localparam int Y_W = $clog2(VIDEO_HEIGHT);

    // True when origin <= pos < origin + size. Evaluated at 11 bits so that a
    // sprite hanging off the right/bottom edge cannot wrap its far bound.
    function automatic logic in_span(input logic [10:0] pos,
                                     input logic [10:0] origin,
                                     input logic [10:0] size);
        return (pos >= origin) && (pos < origin + size);
    endfunction

endpackage

// File: rtl/sprite_anim_renderer_ram.sv
// Single-port synchronous RAM with registered read data. The renderer uses
// it read-only (write enable tied low) for both the image and the palette.
module sprite_anim_renderer_ram #(
    parameter int    DATA_W    = 8,
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = ""
) (
    input  logic                     i_clk,
    input  logic                     i_wen,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // One-cycle read latency; optional write at the same address.
    always_ff @(posedge i_clk) begin
        if (i_wen)
            r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/sprite_anim_renderer.sv
// Animated sprite renderer: maps the current raster pixel into a multi-frame
// indexed image, looks the index up in a palette and reports colour/opacity
// two cycles later. A small FSM steps animation frames on frame_start pulses.
module sprite_anim_renderer #(
    parameter int    SPRITE_W        = 50,
    parameter int    SPRITE_H        = 50,
    parameter int    NUM_FRAMES      = 4,
    parameter int    HOLD_FRAMES     = 6,
    parameter int    BITS_PER_COLOR  = sprite_anim_renderer_pkg::BITS_PER_COLOR,
    parameter int    PALETTE_COLORS  = 256,
    parameter int    TRANSPARENT_IDX = 0,
    parameter string MEMFILE_PREFIX  = {sprite_anim_renderer_pkg::FILES_PATH, "bananasplash"}
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [sprite_anim_renderer_pkg::X_W-1:0] x,
    input  logic [sprite_anim_renderer_pkg::Y_W-1:0] y,
    input  logic [sprite_anim_renderer_pkg::X_W-1:0] sprite_x,
    input  logic [sprite_anim_renderer_pkg::Y_W-1:0] sprite_y,
    input  logic                                   frame_start,
    input  logic                                   trigger,
    input  logic                                   loop_en,
    output logic [BITS_PER_COLOR-1:0]              pix_color,
    output logic                                   pix_opaque,
    output logic                                   busy,
    output logic                                   done
);

    import sprite_anim_renderer_pkg::*;

    localparam int FRAME_PIX = SPRITE_W * SPRITE_H;
    localparam int IMG_DEPTH = NUM_FRAMES * FRAME_PIX;
    localparam int ADDR_W    = $clog2(IMG_DEPTH);
    localparam int IDX_W     = $clog2(PALETTE_COLORS);
    localparam int FIDX_W    = (NUM_FRAMES  > 1) ? $clog2(NUM_FRAMES)  : 1;
    localparam int HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD  = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [IDX_W-1:0]  TRANSP     = IDX_W'(TRANSPARENT_IDX);

    localparam string IMAGE_FILE = (MEMFILE_PREFIX == "") ? "" : {MEMFILE_PREFIX, "image.mem"};
    localparam string COLOR_FILE = (MEMFILE_PREFIX == "") ? "" : {MEMFILE_PREFIX, "colors.mem"};

    // Animation state encoding.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [FIDX_W-1:0]         r_frame_idx;
    logic [FIDX_W-1:0]         w_frame_idx_nxt;
    logic [HOLD_W-1:0]         r_hold_cnt;
    logic [HOLD_W-1:0]         w_hold_cnt_nxt;
    logic                      w_play;

    logic                      w_in_box;
    logic [X_W-1:0]            w_dx;
    logic [Y_W-1:0]            w_dy;
    logic [ADDR_W-1:0]         w_img_addr;
    logic [IDX_W-1:0]          w_color_idx;
    logic [BITS_PER_COLOR-1:0] w_pal_color;

    logic                      r_in_box_p1;
    logic                      r_in_box_p2;
    logic                      r_play_p1;
    logic                      r_play_p2;
    logic [IDX_W-1:0]          r_idx_p2;

    assign w_play = (r_state == S_PLAY);
    assign busy   = (r_state == S_ARMED) || (r_state == S_PLAY);
    assign done   = (r_state == S_DONE);

    // Stage 0: hit test and image address for the pixel on the inputs now.
    assign w_in_box = in_span(11'(x), 11'(sprite_x), 11'(SPRITE_W)) &&
                      in_span(11'(y), 11'(sprite_y), 11'(SPRITE_H));
    assign w_dx     = x - sprite_x;
    assign w_dy     = y - sprite_y;

    // Out-of-box pixels present address 0 so the RAM never sees a stray index.
    always_comb begin
        w_img_addr = '0;
        if (w_in_box)
            w_img_addr = ADDR_W'(w_dx)
                       + ADDR_W'(SPRITE_W)  * ADDR_W'(w_dy)
                       + ADDR_W'(FRAME_PIX) * ADDR_W'(r_frame_idx);
    end

    // Stage 1: image RAM returns the palette index.
    sprite_anim_renderer_ram #(
        .DATA_W    (IDX_W),
        .DEPTH     (IMG_DEPTH),
        .INIT_FILE (IMAGE_FILE)
    ) u_image_ram (
        .i_clk   (clk),
        .i_wen   (1'b0),
        .i_addr  (w_img_addr),
        .i_wdata ('0),
        .o_rdata (w_color_idx)
    );

    // Stage 2: palette RAM returns the colour.
    sprite_anim_renderer_ram #(
        .DATA_W    (BITS_PER_COLOR),
        .DEPTH     (PALETTE_COLORS),
        .INIT_FILE (COLOR_FILE)
    ) u_palette_ram (
        .i_clk   (clk),
        .i_wen   (1'b0),
        .i_addr  (w_color_idx),
        .i_wdata ('0),
        .o_rdata (w_pal_color)
    );

    assign pix_color  = w_pal_color;
    assign pix_opaque = r_in_box_p2 & r_play_p2 & (r_idx_p2 != TRANSP);

    // Delay hit and play flags two stages so they line up with the palette output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_box_p1 <= 1'b0;
            r_in_box_p2 <= 1'b0;
            r_play_p1   <= 1'b0;
            r_play_p2   <= 1'b0;
        end else begin
            r_in_box_p1 <= w_in_box;
            r_in_box_p2 <= r_in_box_p1;
            r_play_p1   <= w_play;
            r_play_p2   <= r_play_p1;
        end
    end

    // Keep the palette index alongside its colour for the transparency test.
    always_ff @(posedge clk) begin
        r_idx_p2 <= w_color_idx;
    end

    // Animation sequencing; frame_idx only moves on a frame_start cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_idx_nxt = r_frame_idx;
        w_hold_cnt_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (trigger)
                    w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (frame_start) begin
                    w_state_nxt     = S_PLAY;
                    w_frame_idx_nxt = '0;
                    w_hold_cnt_nxt  = '0;
                end
            end
            S_PLAY: begin
                if (frame_start) begin
                    if (r_hold_cnt == LAST_HOLD) begin
                        w_hold_cnt_nxt = '0;
                        if (r_frame_idx == LAST_FRAME) begin
                            w_frame_idx_nxt = '0;
                            if (!loop_en)
                                w_state_nxt = S_DONE;
                        end else begin
                            w_frame_idx_nxt = r_frame_idx + FIDX_W'(1);
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, frame and hold registers; reset aborts any animation at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_frame_idx <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_idx <= w_frame_idx_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

endmodule

// File: doc/sprite_anim_renderer.md
SPRITE_ANIM_RENDERER -- requirements
Module: sprite_anim_renderer

Interface
REQ-001 The block SHALL have parameter SPRITE_W, default 50, sprite width in pixels.
REQ-002 The block SHALL have parameter SPRITE_H, default 50, sprite height in pixels.
REQ-003 The block SHALL have parameter NUM_FRAMES, default 4, animation frames stored back-to-back in one image memory.
REQ-004 The block SHALL have parameter HOLD_FRAMES, default 6, screen frames each animation frame is shown.
REQ-005 The block SHALL have parameter BITS_PER_COLOR, default 12, output colour width.
REQ-006 The block SHALL have parameter PALETTE_COLORS, default 256, palette depth.
REQ-007 The block SHALL have parameter TRANSPARENT_IDX, default 0, palette index treated as transparent.
REQ-008 The block SHALL have parameter MEMFILE_PREFIX, default "../assetsMemFiles/bananasplash", prefix for the "image.mem" and "colors.mem" init files.
REQ-009 clk input 1: single clock, all logic rising-edge.
REQ-010 reset input 1: asynchronous, active-high.
REQ-011 x input 10; y input 9: current VGA pixel coordinate.
REQ-012 sprite_x input 10; sprite_y input 9: sprite top-left corner.
REQ-013 frame_start input 1: one-cycle pulse at start of each screen frame.
REQ-014 trigger input 1: one-cycle request to play the animation.
REQ-015 loop_en input 1: 1 = restart at frame 0 after the last frame.
REQ-016 pix_color output BITS_PER_COLOR: palette colour for the pixel presented 2 cycles earlier.
REQ-017 pix_opaque output 1: 1 = pix_color is to be drawn.
REQ-018 busy output 1: high in ARMED or PLAY.
REQ-019 done output 1: one-cycle pulse when a non-looping animation ends.

Function
REQ-020 in_box SHALL be 1 iff sprite_x <= x < sprite_x+SPRITE_W and sprite_y <= y < sprite_y+SPRITE_H, with comparisons at 11/10 bits so that sprite_x+SPRITE_W cannot wrap.
REQ-021 Image address SHALL be (x-sprite_x) + SPRITE_W*(y-sprite_y) + frame_idx*SPRITE_W*SPRITE_H, width $clog2(NUM_FRAMES*SPRITE_W*SPRITE_H).
REQ-022 The image address SHALL be forced to 0 when in_box=0, so that no out-of-range address is driven.
REQ-023 Latency SHALL be exactly 2 cycles: cycle 1 image-RAM read, cycle 2 palette-RAM read; in_box and play-state flags SHALL be delayed 2 stages to align with pix_color.
REQ-024 pix_opaque SHALL equal delayed in_box AND delayed (state==PLAY) AND (delayed colour index != TRANSPARENT_IDX).
REQ-025 FSM states SHALL be IDLE, ARMED, PLAY, DONE.
REQ-026 IDLE: trigger -> ARMED; a simultaneous frame_start SHALL NOT start play.
REQ-027 ARMED: frame_start -> PLAY, with frame_idx=0 and hold_cnt=0.
REQ-028 PLAY: each frame_start increments hold_cnt; at hold_cnt==HOLD_FRAMES-1, hold_cnt->0 and frame_idx increments.
REQ-029 PLAY on the last frame's final hold: loop_en=1 -> frame_idx=0, stay in PLAY; loop_en=0 -> DONE.
REQ-030 DONE SHALL last one cycle, assert done, then -> IDLE.
REQ-031 trigger in ARMED, PLAY or DONE SHALL be ignored.
REQ-032 frame_idx SHALL change only on a frame_start cycle (no mid-frame tearing).
REQ-033 busy SHALL be combinational from state.

Reset
REQ-034 On reset: state=IDLE, frame_idx=0, hold_cnt=0, pipeline flags=0, pix_opaque=0, done=0, busy=0.
REQ-035 pix_color SHALL be don't-care while pix_opaque=0.
REQ-036 Reset mid-PLAY SHALL abort immediately, with no done pulse.

Structure
REQ-037 VIDEO_WIDTH, VIDEO_HEIGHT, BITS_PER_COLOR and FILES_PATH SHALL live in the shared display package; the state encoding SHALL be local.
REQ-038 Both memories SHALL instantiate the existing RAM sub-module (wEn tied 0); no other sub-module.

Verification
REQ-039 Latency/transparency: sprite at (100,50), state PLAY, x,y=(100,50) with image index 0 -> pix_opaque=0 at cycle+2; x,y=(110,60) with index 5 -> pix_color=palette[5], pix_opaque=1 exactly 2 cycles later.
REQ-040 Bounds: x=149 in box, x=150 out; sprite_x=620, x=639 in, y=sprite_y+50 out -> pix_opaque=0, no address wrap.
REQ-041 Sequencing: trigger, then 24 frame_start pulses (HOLD_FRAMES=6, NUM_FRAMES=4) -> frame_idx 0,1,2,3 each for 6 frames; done pulses once after the 24th pulse past the ARMED->PLAY pulse; busy falls.
REQ-042 Loop: loop_en=1 -> frame_idx wraps 3->0, no done pulse; clearing loop_en before the last hold -> done at the end of that pass.
REQ-043 Simultaneous/ignored events: trigger with frame_start in IDLE -> ARMED, PLAY only at the next frame_start; trigger during PLAY -> no restart.
REQ-044 Reset mid-PLAY at frame_idx=2 -> IDLE, frame_idx=0, done=0, pix_opaque=0 immediately.
